// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly with valid/ready, per-beat scaling, conj-twiddle mode, sticky overflow.
// Optional macro BFLY_ROUND_EN selects round-half-up on the >>F product shift and >>1 scale shift (truncation otherwise).
module butterfly_pipe #(
  parameter int W = 16,
  parameter int F = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [W-1:0] i_even [0:1],
  input  logic signed [W-1:0] i_odd  [0:1],
  input  logic signed [W-1:0] i_twi  [0:1],
  input  logic                i_inv,
  input  logic                i_scale,
  input  logic                i_clr_ovf,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [W-1:0] o_top  [0:1],
  output logic signed [W-1:0] o_btm  [0:1],
  output logic                o_ovf
);
  localparam int PW = 2*W;
  localparam int SW = 2*W + 1;
  localparam int TW = 2*W + 2 - F;

`ifdef BFLY_ROUND_EN
  localparam logic signed [SW-1:0] PROD_BIAS  = (SW'(1) << F) >> 1;
  localparam logic signed [TW-1:0] SCALE_BIAS = TW'(1);
`else
  localparam logic signed [SW-1:0] PROD_BIAS  = '0;
  localparam logic signed [TW-1:0] SCALE_BIAS = '0;
`endif

  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic                w_adv;
  logic                r_s1_valid, r_s1_inv, r_s1_scale;
  logic signed [W-1:0] r_s1_even [0:1];
  logic signed [W-1:0] r_s1_odd  [0:1];
  logic signed [W-1:0] r_s1_twi  [0:1];

  logic                 r_s2_valid, r_s2_inv, r_s2_scale;
  logic signed [W-1:0]  r_s2_even [0:1];
  logic signed [PW-1:0] r_s2_p_rr, r_s2_p_ii, r_s2_p_ri, r_s2_p_ir;

  logic signed [SW-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [SW-1:0] w_prod    [0:1];
  logic signed [W-1:0]  w_top_sat [0:1];
  logic signed [W-1:0]  w_btm_sat [0:1];
  logic [1:0]           w_sat_top, w_sat_btm;

  logic                r_valid, r_ovf;
  logic signed [W-1:0] r_top [0:1];
  logic signed [W-1:0] r_btm [0:1];

  // Global stall: every stage moves together whenever the output slot is free or being drained.
  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_scale <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_s1_even[k] <= '0;
        r_s1_odd[k]  <= '0;
        r_s1_twi[k]  <= '0;
      end
    end else if (w_adv) begin
      r_s1_valid <= i_valid;
      r_s1_inv   <= i_inv;
      r_s1_scale <= i_scale;
      r_s1_even  <= i_even;
      r_s1_odd   <= i_odd;
      r_s1_twi   <= i_twi;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_scale <= 1'b0;
      r_s2_p_rr  <= '0;
      r_s2_p_ii  <= '0;
      r_s2_p_ri  <= '0;
      r_s2_p_ir  <= '0;
      for (int k = 0; k < 2; k++) begin
        r_s2_even[k] <= '0;
      end
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_inv   <= r_s1_inv;
      r_s2_scale <= r_s1_scale;
      r_s2_even  <= r_s1_even;
      r_s2_p_rr  <= PW'(r_s1_odd[0]) * PW'(r_s1_twi[0]);
      r_s2_p_ii  <= PW'(r_s1_odd[1]) * PW'(r_s1_twi[1]);
      r_s2_p_ri  <= PW'(r_s1_odd[0]) * PW'(r_s1_twi[1]);
      r_s2_p_ir  <= PW'(r_s1_odd[1]) * PW'(r_s1_twi[0]);
    end
  end

  assign w_rr = {r_s2_p_rr[PW-1], r_s2_p_rr};
  assign w_ii = {r_s2_p_ii[PW-1], r_s2_p_ii};
  assign w_ri = {r_s2_p_ri[PW-1], r_s2_p_ri};
  assign w_ir = {r_s2_p_ir[PW-1], r_s2_p_ir};

  // Conjugation lives in the sum so a twiddle imag of -2^(W-1) never needs negating.
  assign w_prod[0] = r_s2_inv ? (w_rr + w_ii) : (w_rr - w_ii);
  assign w_prod[1] = r_s2_inv ? (w_ir - w_ri) : (w_ri + w_ir);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [SW-1:0] w_prod_sh;
      logic signed [TW-1:0] w_prod_q, w_even_x, w_top_f, w_btm_f, w_top_s, w_btm_s;

      assign w_prod_sh = (w_prod[gi] + PROD_BIAS) >>> F;
      assign w_prod_q  = TW'(w_prod_sh);
      assign w_even_x  = TW'(r_s2_even[gi]);
      assign w_top_f   = w_even_x + w_prod_q;
      assign w_btm_f   = w_even_x - w_prod_q;
      assign w_top_s   = r_s2_scale ? ((w_top_f + SCALE_BIAS) >>> 1) : w_top_f;
      assign w_btm_s   = r_s2_scale ? ((w_btm_f + SCALE_BIAS) >>> 1) : w_btm_f;

      assign w_sat_top[gi] = (w_top_s > SAT_MAX) || (w_top_s < SAT_MIN);
      assign w_sat_btm[gi] = (w_btm_s > SAT_MAX) || (w_btm_s < SAT_MIN);
      assign w_top_sat[gi] = (w_top_s > SAT_MAX) ? SAT_MAX[W-1:0] :
                             (w_top_s < SAT_MIN) ? SAT_MIN[W-1:0] : w_top_s[W-1:0];
      assign w_btm_sat[gi] = (w_btm_s > SAT_MAX) ? SAT_MAX[W-1:0] :
                             (w_btm_s < SAT_MIN) ? SAT_MIN[W-1:0] : w_btm_s[W-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_top[k] <= '0;
        r_btm[k] <= '0;
      end
    end else begin
      if (w_adv) begin
        r_valid <= r_s2_valid;
        r_top   <= w_top_sat;
        r_btm   <= w_btm_sat;
      end
      // A saturating output beat outranks a clear in the same cycle.
      if (w_adv && r_s2_valid && (|{w_sat_top, w_sat_btm})) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_top   = r_top;
  assign o_btm   = r_btm;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed, self-checking bench for butterfly_pipe (W=16, F=15), including backpressure and async reset.
// Expected values for the rounding-sensitive vectors follow BFLY_ROUND_EN when it is defined.
module tb_butterfly_pipe;
  logic               i_clk;
  logic               i_rst_n;
  logic               i_valid;
  logic               o_ready;
  logic signed [15:0] even [0:1];
  logic signed [15:0] odd  [0:1];
  logic signed [15:0] twi  [0:1];
  logic               i_inv;
  logic               i_scale;
  logic               i_clr_ovf;
  logic               o_valid;
  logic               i_ready;
  logic signed [15:0] o_top [0:1];
  logic signed [15:0] o_btm [0:1];
  logic               o_ovf;

  int checks;
  int failures;

`ifdef BFLY_ROUND_EN
  localparam int ID_TOP = 24576;
  localparam int ID_BTM = 8192;
  localparam int SC_TOP = 32767;
  localparam int SC_BTM = 1;
`else
  localparam int ID_TOP = 24575;
  localparam int ID_BTM = 8193;
  localparam int SC_TOP = 32766;
  localparam int SC_BTM = 0;
`endif

  butterfly_pipe #(.W(16), .F(15)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_even    (even),
    .i_odd     (odd),
    .i_twi     (twi),
    .i_inv     (i_inv),
    .i_scale   (i_scale),
    .i_clr_ovf (i_clr_ovf),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_top     (o_top),
    .o_btm     (o_btm),
    .o_ovf     (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int tr, input int ti, input int br, input int bi);
    chk({tag, "_top_re"}, int'(o_top[0]), tr);
    chk({tag, "_top_im"}, int'(o_top[1]), ti);
    chk({tag, "_btm_re"}, int'(o_btm[0]), br);
    chk({tag, "_btm_im"}, int'(o_btm[1]), bi);
  endtask

  task automatic set_in(input int er, input int ei, input int orr, input int oi,
                        input int tr, input int ti, input bit inv, input bit sc);
    even[0] = 16'(er);  even[1] = 16'(ei);
    odd[0]  = 16'(orr); odd[1]  = 16'(oi);
    twi[0]  = 16'(tr);  twi[1]  = 16'(ti);
    i_inv   = inv;
    i_scale = sc;
  endtask

  // Called at a negedge with an empty pipe; returns at the negedge where the result is visible.
  task automatic beat(input string tag, input int er, input int ei, input int orr, input int oi,
                      input int tr, input int ti, input bit inv, input bit sc, input bit clr,
                      input int xtr, input int xti, input int xbr, input int xbi, input bit xovf);
    int lat;
    set_in(er, ei, orr, oi, tr, ti, inv, sc);
    i_valid   = 1'b1;
    i_clr_ovf = clr;
    #1;
    chk({tag, "_ready"}, int'(o_ready), 1);
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_valid = 1'b0;
    while (!o_valid && lat < 10) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_valid"}, int'(o_valid), 1);
    chk_out(tag, xtr, xti, xbr, xbi);
    chk({tag, "_ovf"}, int'(o_ovf), int'(xovf));
    i_clr_ovf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    int stall_start;
    int hold_tr, hold_ti, hold_br, hold_bi;
    checks      = 0;
    failures    = 0;
    i_clk       = 1'b0;
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_clr_ovf   = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_ovf", int'(o_ovf), 0);
    chk_out("rst", 0, 0, 0, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Twiddle and mode vectors
    beat("ident", 16384, 0, 8192, 0, 32767, 0, 1'b0, 1'b0, 1'b0, ID_TOP, 0, ID_BTM, 0, 1'b0);
    beat("negj", 16384, 0, 8192, 0, 0, -32768, 1'b0, 1'b0, 1'b0, 16384, -8192, 16384, 8192, 1'b0);
    beat("negj_inv", 16384, 0, 8192, 0, 0, -32768, 1'b1, 1'b0, 1'b0, 16384, 8192, 16384, -8192, 1'b0);
    beat("sat", 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 1'b0, 32767, 0, 1, 0, 1'b1);
    beat("sat_scale", 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1, 1'b0, SC_TOP, 0, SC_BTM, 0, 1'b1);

    // Clear pulse with no beat in flight
    i_clr_ovf = 1'b1;
    @(negedge i_clk);
    i_clr_ovf = 1'b0;
    chk("clr_ovf", int'(o_ovf), 0);

    // Clear held while a saturating beat is produced: set wins
    beat("clr_and_sat", 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 1'b1, 32767, 0, 1, 0, 1'b1);
    @(negedge i_clk);
    chk("ovf_sticky", int'(o_ovf), 1);

    // Backpressure: 6 back-to-back beats, i_ready low for 4 cycles after the first output
    sent = 0;
    recv = 0;
    stall_start = -100;
    hold_tr = 0; hold_ti = 0; hold_br = 0; hold_bi = 0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      i_ready = !(cyc >= stall_start && cyc < stall_start + 4);
      if (sent < 6) begin
        set_in(100*sent, -50*sent, 200, 400*sent, 16384, 0, 1'b0, 1'b0);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (!i_ready) begin
        chk("bp_ready_low", int'(o_ready), 0);
        if (cyc > stall_start) begin
          chk("bp_hold_valid", int'(o_valid), 1);
          chk_out("bp_hold", hold_tr, hold_ti, hold_br, hold_bi);
        end
      end
      if (o_valid && i_ready) begin
        chk_out("bp_data", 100*recv + 100, 150*recv, 100*recv - 100, -250*recv);
        recv++;
        if (recv == 1) stall_start = cyc + 1;
      end
      hold_tr = int'(o_top[0]); hold_ti = int'(o_top[1]);
      hold_br = int'(o_btm[0]); hold_bi = int'(o_btm[1]);
      if (i_valid && o_ready) sent++;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_recv", recv, 6);
    @(negedge i_clk);
    chk("bp_drained", int'(o_valid), 0);

    // Async reset with 3 beats in flight
    for (int k = 0; k < 3; k++) begin
      set_in(100*(k+1), -50*(k+1), 200, 400*(k+1), 16384, 0, 1'b0, 1'b0);
      i_valid = 1'b1;
      @(posedge i_clk);
      if (k < 2) @(negedge i_clk);
    end
    #2;
    i_valid = 1'b0;
    chk("rst_pre_valid", int'(o_valid), 1);
    chk("rst_pre_ovf", int'(o_ovf), 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_ovf", int'(o_ovf), 0);
    chk_out("arst", 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("arst_no_stale", int'(o_valid), 0);
    beat("post_rst", 16384, 0, 8192, 0, 32767, 0, 1'b0, 1'b0, 1'b0, ID_TOP, 0, ID_BTM, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
